rom_port_arbiter: RTL and testbench

Shares the single synchronous program-ROM block RAM port among three requesters: the HPS download stream (writes), the CPU instruction/data fetch path (reads), and the debug/high-score reader (reads). It sits between those requesters and the ROM memory, issues one access at a time through a small state machine, and returns read data and a one-cycle acknowledge to the winning requester. Fixed priority is download > CPU > debug, with a starvation guard that lets debug through under sustained CPU traffic.

---
 rtl/rom_port_arbiter.sv | 175 +++++++++++++++++
 tb/tb_rom_port_arbiter.sv | 267 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/rom_port_arbiter.sv
// rom_port_arbiter
//
// Shares the single synchronous program-ROM port between three requesters:
// the HPS download stream (writes), the CPU fetch path (reads) and the
// debug/high-score reader (reads). One access runs at a time through a
// four-state machine (IDLE -> ISSUE -> [FETCH] -> ACK). Priority is
// download > CPU > debug. A starvation counter forces debug through after
// STARVE_MAX consecutive CPU grants while debug is waiting.
//
// Ports
//   clk, reset         system clock, synchronous active-high reset
//   dl_req/dl_a/dl_d   download write request, address, data
//   dl_ack             one-cycle write-complete pulse
//   cpu_req/cpu_a      CPU read request and address
//   cpu_dout/cpu_ack   registered CPU read data (held), one-cycle ack
//   dbg_req/dbg_a      debug read request and address
//   dbg_dout/dbg_ack   registered debug read data (held), one-cycle ack
//   rom_a/rom_din      registered ROM address and write data
//   rom_we             registered ROM write enable
//   rom_dout           ROM read data, valid the cycle after rom_a is sampled
//   busy               high whenever the machine is not in IDLE

module rom_port_arbiter #(
    parameter int AW         = 13,
    parameter int DW         = 8,
    parameter int STARVE_MAX = 4
) (
    input  logic          clk,
    input  logic          reset,

    input  logic          dl_req,
    input  logic [AW-1:0] dl_a,
    input  logic [DW-1:0] dl_d,
    output logic          dl_ack,

    input  logic          cpu_req,
    input  logic [AW-1:0] cpu_a,
    output logic [DW-1:0] cpu_dout,
    output logic          cpu_ack,

    input  logic          dbg_req,
    input  logic [AW-1:0] dbg_a,
    output logic [DW-1:0] dbg_dout,
    output logic          dbg_ack,

    output logic [AW-1:0] rom_a,
    output logic [DW-1:0] rom_din,
    output logic          rom_we,
    input  logic [DW-1:0] rom_dout,

    output logic          busy
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        FETCH = 2'd2,
        ACK   = 2'd3
    } state_t;

    typedef enum logic [1:0] {
        SEL_DL  = 2'd0,
        SEL_CPU = 2'd1,
        SEL_DBG = 2'd2
    } sel_t;

    localparam logic [3:0] STARVE_LIM = 4'(STARVE_MAX);

    state_t     state;
    sel_t       sel;         // requester owning the access in flight
    logic [3:0] starve_cnt;  // CPU grants taken while debug was waiting

    // Winner selection, evaluated every cycle but only acted on in IDLE.
    logic grant_any;
    sel_t grant_sel;

    always_comb begin
        grant_any = 1'b1;
        grant_sel = SEL_DL;
        if (dl_req) begin
            grant_sel = SEL_DL;
        end else if (dbg_req && (starve_cnt == STARVE_LIM)) begin
            // Debug has waited out STARVE_MAX CPU grants: let it jump the CPU.
            grant_sel = SEL_DBG;
        end else if (cpu_req) begin
            grant_sel = SEL_CPU;
        end else if (dbg_req) begin
            grant_sel = SEL_DBG;
        end else begin
            grant_any = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            state      <= IDLE;
            sel        <= SEL_DL;
            starve_cnt <= '0;
            rom_a      <= '0;
            rom_din    <= '0;
            rom_we     <= 1'b0;
            cpu_dout   <= '0;
            dbg_dout   <= '0;
            dl_ack     <= 1'b0;
            cpu_ack    <= 1'b0;
            dbg_ack    <= 1'b0;
            busy       <= 1'b0;
        end else begin
            // Acks are single-cycle: only the transition into ACK raises one.
            dl_ack  <= 1'b0;
            cpu_ack <= 1'b0;
            dbg_ack <= 1'b0;

            case (state)
                IDLE: begin
                    if (grant_any) begin
                        state <= ISSUE;
                        busy  <= 1'b1;
                        sel   <= grant_sel;
                        case (grant_sel)
                            SEL_DL: begin
                                rom_a   <= dl_a;
                                rom_din <= dl_d;
                                rom_we  <= 1'b1;
                            end
                            SEL_CPU: rom_a <= cpu_a;
                            default: rom_a <= dbg_a;
                        endcase
                    end

                    // A download grant neither advances nor clears the count;
                    // otherwise an idle debug port always clears it.
                    if (grant_any && (grant_sel == SEL_DL)) begin
                        starve_cnt <= starve_cnt;
                    end else if (grant_any && (grant_sel == SEL_DBG)) begin
                        starve_cnt <= '0;
                    end else if (!dbg_req) begin
                        starve_cnt <= '0;
                    end else if (grant_any && (grant_sel == SEL_CPU) &&
                                 (starve_cnt != STARVE_LIM)) begin
                        starve_cnt <= starve_cnt + 4'd1;
                    end
                end

                ISSUE: begin
                    // The ROM sampled rom_a/rom_we at the edge ending this cycle.
                    rom_we <= 1'b0;
                    if (sel == SEL_DL) begin
                        state  <= ACK;
                        dl_ack <= 1'b1;
                    end else begin
                        state <= FETCH;
                    end
                end

                FETCH: begin
                    state <= ACK;
                    if (sel == SEL_CPU) begin
                        cpu_dout <= rom_dout;
                        cpu_ack  <= 1'b1;
                    end else begin
                        dbg_dout <= rom_dout;
                        dbg_ack  <= 1'b1;
                    end
                end

                default: begin
                    state <= IDLE;
                    busy  <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_rom_port_arbiter.sv
// tb_rom_port_arbiter
//
// Directed bench for rom_port_arbiter with a behavioural synchronous ROM
// (read-first, one-cycle read latency). Expected values are hand-derived.

module tb_rom_port_arbiter;

    localparam int AW = 13;
    localparam int DW = 8;
    localparam int BOUND = 20;

    logic          clk = 1'b0;
    logic          reset;
    logic          dl_req, cpu_req, dbg_req;
    logic [AW-1:0] dl_a, cpu_a, dbg_a;
    logic [DW-1:0] dl_d;
    logic          dl_ack, cpu_ack, dbg_ack;
    logic [DW-1:0] cpu_dout, dbg_dout;
    logic [AW-1:0] rom_a;
    logic [DW-1:0] rom_din;
    logic          rom_we;
    logic [DW-1:0] rom_dout;
    logic          busy;

    // Preload port into the ROM model, used while the DUT is in reset.
    logic          pre_we;
    logic [AW-1:0] pre_a;
    logic [DW-1:0] pre_d;

    int n_checks = 0;
    int n_fail   = 0;

    always #5 clk = ~clk;

    rom_port_arbiter #(.AW(AW), .DW(DW), .STARVE_MAX(4)) dut (
        .clk(clk), .reset(reset),
        .dl_req(dl_req), .dl_a(dl_a), .dl_d(dl_d), .dl_ack(dl_ack),
        .cpu_req(cpu_req), .cpu_a(cpu_a), .cpu_dout(cpu_dout), .cpu_ack(cpu_ack),
        .dbg_req(dbg_req), .dbg_a(dbg_a), .dbg_dout(dbg_dout), .dbg_ack(dbg_ack),
        .rom_a(rom_a), .rom_din(rom_din), .rom_we(rom_we), .rom_dout(rom_dout),
        .busy(busy)
    );

    logic [DW-1:0] mem [0:(1<<AW)-1];

    always @(posedge clk) begin
        if (pre_we)
            mem[pre_a] <= pre_d;
        else if (rom_we)
            mem[rom_a] <= rom_din;
        rom_dout <= mem[rom_a];
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
        end
    endtask

    task automatic preload(input logic [AW-1:0] a, input logic [DW-1:0] d);
        pre_a  = a;
        pre_d  = d;
        pre_we = 1'b1;
        @(negedge clk);
        pre_we = 1'b0;
    endtask

    // Cycles (negedges) until the selected ack is seen; -1 on timeout.
    task automatic wait_ack(input int which, output int cyc);
        cyc = -1;
        for (int i = 1; i <= BOUND; i++) begin
            @(negedge clk);
            if ((which == 0 && dl_ack) || (which == 1 && cpu_ack) ||
                (which == 2 && dbg_ack)) begin
                cyc = i;
                break;
            end
        end
    endtask

    task automatic cpu_read(input logic [AW-1:0] a, output logic [DW-1:0] d, output int cyc);
        cpu_a   = a;
        cpu_req = 1'b1;
        wait_ack(1, cyc);
        d       = cpu_dout;
        cpu_req = 1'b0;
        @(negedge clk);
    endtask

    task automatic count_cpu_until_dbg(output int n_cpu, output int ok);
        n_cpu = 0;
        ok    = 0;
        for (int i = 0; i < 200; i++) begin
            @(negedge clk);
            if (cpu_ack) n_cpu++;
            if (dbg_ack) begin
                dbg_req = 1'b0;
                ok      = 1;
                break;
            end
        end
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    initial begin
        logic [2:0]    ackv;
        logic          other;
        logic [DW-1:0] d;
        int            cyc, n, ok, multi;
        int            order [$];
        logic [2:0]    done;

        reset = 1'b1;
        dl_req = 1'b0; cpu_req = 1'b0; dbg_req = 1'b0;
        dl_a = '0; dl_d = '0; cpu_a = '0; dbg_a = '0;
        pre_we = 1'b0; pre_a = '0; pre_d = '0;
        repeat (2) @(negedge clk);
        preload(13'h1234, 8'h5A);
        preload(13'h0010, 8'h21);
        preload(13'h0020, 8'h42);
        preload(13'h0400, 8'hA5);
        preload(13'h0401, 8'h3C);

        // Reset state
        check("rst_rom_we", 32'(rom_we), 32'h0);
        check("rst_rom_a", 32'(rom_a), 32'h0);
        check("rst_rom_din", 32'(rom_din), 32'h0);
        check("rst_acks", 32'({dl_ack, cpu_ack, dbg_ack}), 32'h0);
        check("rst_douts", 32'({cpu_dout, dbg_dout}), 32'h0);
        check("rst_busy", 32'(busy), 32'h0);
        reset = 1'b0;
        @(negedge clk);

        // Single CPU read: ack in the 3rd cycle after sampling
        cpu_a   = 13'h1234;
        cpu_req = 1'b1;
        other   = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge clk);
            ackv[i] = cpu_ack;
            other   = other | dl_ack | dbg_ack;
            if (i == 0) check("rd_busy", 32'(busy), 32'h1);
        end
        check("rd_ack_timing", 32'(ackv), 32'h4);
        check("rd_dout", 32'(cpu_dout), 32'h5A);
        check("rd_other_acks", 32'(other), 32'h0);
        cpu_req = 1'b0;
        @(negedge clk);
        check("rd_ack_pulse", 32'(cpu_ack), 32'h0);
        check("rd_busy_idle", 32'(busy), 32'h0);

        // Download write then CPU read-back
        dl_a   = 13'h0100;
        dl_d   = 8'hC3;
        dl_req = 1'b1;
        @(negedge clk);
        check("wr_we_high", 32'(rom_we), 32'h1);
        check("wr_rom_a", 32'(rom_a), 32'h0100);
        check("wr_rom_din", 32'(rom_din), 32'hC3);
        check("wr_ack_early", 32'(dl_ack), 32'h0);
        @(negedge clk);
        check("wr_we_low", 32'(rom_we), 32'h0);
        check("wr_ack", 32'(dl_ack), 32'h1);
        dl_req = 1'b0;
        @(negedge clk);
        check("wr_ack_pulse", 32'(dl_ack), 32'h0);
        cpu_read(13'h0100, d, cyc);
        check("wr_readback_lat", 32'(cyc), 32'd3);
        check("wr_readback", 32'(d), 32'hC3);

        // Priority: all three at once
        dl_a = 13'h0030; dl_d = 8'h77;
        cpu_a = 13'h0010; dbg_a = 13'h0020;
        dl_req = 1'b1; cpu_req = 1'b1; dbg_req = 1'b1;
        done  = 3'b000;
        multi = 0;
        for (int i = 0; i < 60 && done != 3'b111; i++) begin
            @(negedge clk);
            if ((32'(dl_ack) + 32'(cpu_ack) + 32'(dbg_ack)) > 1) multi++;
            if (dl_ack)  begin order.push_back(0); dl_req  = 1'b0; done[0] = 1'b1; end
            if (cpu_ack) begin order.push_back(1); cpu_req = 1'b0; done[1] = 1'b1; end
            if (dbg_ack) begin order.push_back(2); dbg_req = 1'b0; done[2] = 1'b1; end
        end
        check("pri_all_done", 32'(done), 32'h7);
        check("pri_n_acks", 32'(order.size()), 32'd3);
        check("pri_multi", 32'(multi), 32'd0);
        if (order.size() == 3) begin
            check("pri_first_dl", 32'(order[0]), 32'd0);
            check("pri_second_cpu", 32'(order[1]), 32'd1);
            check("pri_third_dbg", 32'(order[2]), 32'd2);
        end
        check("pri_cpu_dout", 32'(cpu_dout), 32'h21);
        check("pri_dbg_dout", 32'(dbg_dout), 32'h42);
        @(negedge clk);
        cpu_read(13'h0030, d, cyc);
        check("pri_dl_written", 32'(d), 32'h77);

        // Starvation guard
        cpu_a = 13'h0010; dbg_a = 13'h0020;
        cpu_req = 1'b1; dbg_req = 1'b1;
        count_cpu_until_dbg(n, ok);
        check("starve_dbg_seen", 32'(ok), 32'd1);
        check("starve_cpu_before_dbg", 32'(n), 32'd4);
        check("starve_dbg_dout", 32'(dbg_dout), 32'h42);
        wait_ack(1, cyc);
        check("starve_cpu_resumes", 32'(cyc), 32'd4);
        dbg_req = 1'b1;
        count_cpu_until_dbg(n, ok);
        check("starve_cnt_cleared", 32'(n), 32'd4);
        cpu_req = 1'b0;
        repeat (2) @(negedge clk);

        // Reset during ISSUE of a write
        dl_a = 13'h0200; dl_d = 8'h99; dl_req = 1'b1;
        @(negedge clk);
        check("rstw_we_issue", 32'(rom_we), 32'h1);
        reset = 1'b1;
        dl_d  = 8'h66;
        @(negedge clk);
        check("rstw_we", 32'(rom_we), 32'h0);
        check("rstw_no_ack", 32'({dl_ack, cpu_ack, dbg_ack}), 32'h0);
        check("rstw_busy", 32'(busy), 32'h0);
        check("rstw_rom_a", 32'(rom_a), 32'h0);
        check("rstw_rom_din", 32'(rom_din), 32'h0);
        check("rstw_douts", 32'({cpu_dout, dbg_dout}), 32'h0);
        reset = 1'b0;
        wait_ack(0, cyc);
        check("rstw_resume_lat", 32'(cyc), 32'd2);
        dl_req = 1'b0;
        @(negedge clk);
        cpu_read(13'h0200, d, cyc);
        check("rstw_readback", 32'(d), 32'h66);

        // Address change after grant
        cpu_a   = 13'h0400;
        cpu_req = 1'b1;
        @(negedge clk);
        cpu_a = 13'h0401;
        wait_ack(1, cyc);
        check("addr_chg_lat", 32'(cyc), 32'd2);
        check("addr_chg_dout", 32'(cpu_dout), 32'hA5);
        cpu_req = 1'b0;
        @(negedge clk);

        // Lone debug read
        dbg_a   = 13'h0401;
        dbg_req = 1'b1;
        wait_ack(2, cyc);
        check("dbg_lat", 32'(cyc), 32'd3);
        check("dbg_dout", 32'(dbg_dout), 32'h3C);
        check("dbg_cpu_dout_held", 32'(cpu_dout), 32'hA5);
        dbg_req = 1'b0;
        @(negedge clk);
        check("dbg_ack_pulse", 32'(dbg_ack), 32'h0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
